// File: rtl/mux_cfg_ctrl.sv
// Configuration controller for a bank of predecoded transmission-gate muxes: host words are
// shifted serially into a shadow chain and committed atomically to the active selects on the last word.
module mux_cfg_ctrl #(
   parameter int NUM_MUX = 8,
   parameter int WIDTH   = 4,
   parameter int ADDR_W  = $clog2(WIDTH),
   localparam int CFG_W  = NUM_MUX * ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_W-1:0]          in_data,
   input  logic                       in_last,
   output logic [NUM_MUX*WIDTH-1:0]   sel,
   output logic                       cfg_loaded,
   output logic                       cfg_done,
   output logic                       cfg_err,
   output logic                       scan_out
);

   localparam int CNT_W  = $clog2(NUM_MUX + 2);
   localparam int BCNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_MUX + 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_MUX);
   localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(ADDR_W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [CFG_W-1:0]    shadow_q, shadow_d;
   logic [CFG_W-1:0]    active_q, active_d;
   logic [ADDR_W-1:0]   hold_q,   hold_d;
   logic                last_q,   last_d;
   logic [CNT_W-1:0]    wcnt_q,   wcnt_d;
   logic [BCNT_W-1:0]   bcnt_q,   bcnt_d;
   logic                scan_q,   scan_d;
   logic                loaded_q, loaded_d;
   logic                done_q,   done_d;
   logic                err_q,    err_d;

   assign in_ready = (state_q == IDLE);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      hold_d   = hold_q;
      last_d   = last_q;
      wcnt_d   = wcnt_q;
      bcnt_d   = bcnt_q;
      scan_d   = scan_q;
      loaded_d = loaded_q;
      done_d   = 1'b0;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               hold_d  = in_data;
               last_d  = in_last;
               bcnt_d  = '0;
               // Saturate one past full so an over-long load can never alias to a valid count.
               if (wcnt_q != CNT_MAX) begin
                  wcnt_d = wcnt_q + CNT_W'(1);
               end
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            shadow_d = {hold_q[0], shadow_q[CFG_W-1:1]};
            scan_d   = shadow_q[0];
            hold_d   = hold_q >> 1;
            bcnt_d   = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BIT_LAST) begin
               bcnt_d  = '0;
               state_d = last_q ? COMMIT : IDLE;
            end
         end

         COMMIT: begin
            if (wcnt_q == CNT_FULL) begin
               active_d = shadow_q;
               done_d   = 1'b1;
               loaded_d = 1'b1;
            end else begin
               err_d    = 1'b1;
            end
            wcnt_d  = '0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         active_q <= '0;
         hold_q   <= '0;
         last_q   <= 1'b0;
         wcnt_q   <= '0;
         bcnt_q   <= '0;
         scan_q   <= 1'b0;
         loaded_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         hold_q   <= hold_d;
         last_q   <= last_d;
         wcnt_q   <= wcnt_d;
         bcnt_q   <= bcnt_d;
         scan_q   <= scan_d;
         loaded_q <= loaded_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Out-of-range addresses fall back to input 0 so no mux output is ever left floating.
   for (genvar m = 0; m < NUM_MUX; m++) begin : g_mux
      logic [ADDR_W-1:0] addr;
      assign addr = active_q[m*ADDR_W +: ADDR_W];
      for (genvar k = 0; k < WIDTH; k++) begin : g_sel
         if (k == 0) begin : g_zero
            assign sel[m*WIDTH] = (addr == '0) || (32'(addr) >= WIDTH);
         end else begin : g_nz
            assign sel[m*WIDTH + k] = (32'(addr) == k);
         end
      end
   end

   assign cfg_loaded = loaded_q;
   assign cfg_done   = done_q;
   assign cfg_err    = err_q;
   assign scan_out   = scan_q;

endmodule

// File: tb/tb_mux_cfg_ctrl.sv
// Scoreboard bench for mux_cfg_ctrl: drivers push expected commits/scan bits, a negedge monitor checks them.
module tb_mux_cfg_ctrl;

   localparam logic [31:0] SEL_RST = 32'h1111_1111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_data;
   logic        in_last;
   logic [31:0] sel;
   logic        cfg_loaded;
   logic        cfg_done;
   logic        cfg_err;
   logic        scan_out;

   mux_cfg_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .sel        (sel),
      .cfg_loaded (cfg_loaded),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .scan_out   (scan_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] sel;
   } done_t;

   typedef struct {
      int   cyc;
      logic b;
   } scan_t;

   done_t sb_done[$];
   scan_t sb_scan[$];

   int          cyc = 0;
   int          tests = 0;
   int          errors = 0;
   int          last_hs = 0;
   logic [31:0] cur_exp = SEL_RST;
   logic [1:0]  wv [8];
   logic [1:0]  pat_a [8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected commits on cfg_done, expected scan bits by cycle, and checks sel every cycle.
   always @(negedge clk) begin
      done_t d;
      scan_t s;
      if (!rst_n) begin
         cur_exp = SEL_RST;
      end else begin
         if (cfg_done) begin
            if (sb_done.size() == 0) begin
               chk("unexpected_done", 32'(cfg_done), 32'd0);
            end else begin
               d = sb_done.pop_front();
               chk("done_cycle", 32'(cyc), 32'(d.cyc));
               chk("done_sel", sel, d.sel);
               cur_exp = d.sel;
            end
         end
         if (sb_scan.size() > 0 && sb_scan[0].cyc <= cyc) begin
            s = sb_scan.pop_front();
            chk("scan_cycle", 32'(cyc), 32'(s.cyc));
            chk("scan_bit", 32'(scan_out), 32'(s.b));
         end
      end
      chk("sel_hold", sel, cur_exp);
   end

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic send(input logic [1:0] d, input logic l, input int gap_exp);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
      if (gap_exp > 0) chk("ready_spacing", 32'(cyc - last_hs), 32'(gap_exp));
      last_hs = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input logic with_last, input logic [31:0] exp,
                       input logic commit, input logic scan_chk);
      done_t d;
      scan_t s;
      for (int i = 0; i < n; i++) begin
         send(wv[i], with_last && (i == n - 1), (i == 0) ? 0 : 3);
         if (with_last && (i == n - 1) && commit) begin
            d.cyc = last_hs + 4;
            d.sel = exp;
            sb_done.push_back(d);
         end
         if (scan_chk) begin
            s.cyc = last_hs + 2;
            s.b   = pat_a[i][0];
            sb_scan.push_back(s);
            s.cyc = last_hs + 3;
            s.b   = pat_a[i][1];
            sb_scan.push_back(s);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 2'd0;
      in_last  = 1'b0;
      @(negedge clk);
      chk("rst_sel", sel, SEL_RST);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_loaded", 32'(cfg_loaded), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_scan", 32'(scan_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      settle(1);

      // Full load with continuous valid: 0,1,2,3,3,2,1,0
      wv = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      load(8, 1'b1, 32'h1248_8421, 1'b1, 1'b0);
      settle(6);
      chk("t1_loaded", 32'(cfg_loaded), 32'd1);
      chk("t1_err", 32'(cfg_err), 32'd0);

      // Reload all 3s: sel must hold the previous config until cfg_done
      wv = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
      load(8, 1'b1, 32'h8888_8888, 1'b1, 1'b0);
      settle(6);

      // Short load: 5 words then last -> error, no commit
      wv = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      load(5, 1'b1, 32'h0, 1'b0, 1'b0);
      settle(6);
      chk("t4_err", 32'(cfg_err), 32'd1);
      wv = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
      load(8, 1'b1, 32'h4444_4444, 1'b1, 1'b0);
      settle(6);
      chk("t4_err_sticky", 32'(cfg_err), 32'd1);
      chk("t4_loaded", 32'(cfg_loaded), 32'd1);

      // Reset during the SHIFT of word 4
      wv = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      for (int i = 0; i < 3; i++) send(wv[i], 1'b0, (i == 0) ? 0 : 3);
      send(wv[3], 1'b0, 3);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("t5_sel", sel, SEL_RST);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      chk("t5_loaded", 32'(cfg_loaded), 32'd0);
      chk("t5_err", 32'(cfg_err), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      settle(1);
      wv = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
      load(8, 1'b1, 32'h8421_1248, 1'b1, 1'b0);
      settle(6);
      chk("t5_reload_loaded", 32'(cfg_loaded), 32'd1);

      // Scan readback: commit pattern A, then stream 8 words without last
      pat_a = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
      wv = pat_a;
      load(8, 1'b1, 32'h2814_4182, 1'b1, 1'b0);
      settle(6);
      wv = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      load(8, 1'b0, 32'h0, 1'b0, 1'b1);
      settle(8);

      chk("done_queue_empty", 32'(sb_done.size()), 32'd0);
      chk("scan_queue_empty", 32'(sb_scan.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
